// File: rtl/conv_window_scanner.sv
// conv_window_scanner: walks every KxK kernel window over an IMG_H x IMG_W x CH
//   feature map at a runtime stride and emits one beat per window element.
// Latency: start sampled in IDLE at edge N gives the first beat (origin 0,0) from N+1.
// Backpressure: valid/ready; indices advance only on valid && ready, and all
//   outputs hold stable while ready is low.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 launch a scan (IDLE only)
//   stride                window step in rows and columns, latched at start; 0 acts as 1
//   abort                 synchronous return to IDLE, no done pulse
//   ready                 downstream accepts the current beat
//   valid                 beat present
//   org_row, org_col      window origin
//   k_row, k_col, k_ch    kernel offsets and channel within the window
//   addr                  linear input address of the element
//   win_first, win_last   first / last element of a window (gated by valid)
//   busy                  scan in progress
//   done                  one-cycle pulse after the final beat is accepted
module conv_window_scanner #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = 3,
  parameter int CH    = 3,
  localparam int RW   = ($clog2(IMG_H) > 0) ? $clog2(IMG_H) : 1,
  localparam int CWD  = ($clog2(IMG_W) > 0) ? $clog2(IMG_W) : 1,
  localparam int KW   = ($clog2(K) > 0) ? $clog2(K) : 1,
  localparam int HW   = ($clog2(CH) > 0) ? $clog2(CH) : 1,
  localparam int AW   = ($clog2(IMG_W*IMG_H*CH) > 0) ? $clog2(IMG_W*IMG_H*CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     stride,
  input  logic           abort,
  input  logic           ready,
  output logic           valid,
  output logic [RW-1:0]  org_row,
  output logic [CWD-1:0] org_col,
  output logic [KW-1:0]  k_row,
  output logic [KW-1:0]  k_col,
  output logic [HW-1:0]  k_ch,
  output logic [AW-1:0]  addr,
  output logic           win_first,
  output logic           win_last,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [KW-1:0]  K_MAX   = KW'(K - 1);
  localparam logic [HW-1:0]  CH_MAX  = HW'(CH - 1);
  // Largest legal origin on each axis; two guard bits so origin + stride never wraps.
  localparam logic [RW+1:0]  ROW_LIM = (RW + 2)'(IMG_H - K);
  localparam logic [CWD+1:0] COL_LIM = (CWD + 2)'(IMG_W - K);

  state_t       state;
  logic [1:0]   stride_q;

  logic         ch_wrap;
  logic         kcol_wrap;
  logic         krow_wrap;
  logic [CWD+1:0] col_next;
  logic [RW+1:0]  row_next;
  logic         col_step_ok;
  logic         row_step_ok;
  logic         last_beat;
  logic         fire;

  assign ch_wrap     = (k_ch == CH_MAX);
  assign kcol_wrap   = (k_col == K_MAX);
  assign krow_wrap   = (k_row == K_MAX);
  assign col_next    = (CWD + 2)'(org_col) + (CWD + 2)'(stride_q);
  assign row_next    = (RW + 2)'(org_row) + (RW + 2)'(stride_q);
  assign col_step_ok = (col_next <= COL_LIM);
  assign row_step_ok = (row_next <= ROW_LIM);
  assign last_beat   = ch_wrap && kcol_wrap && krow_wrap && !col_step_ok && !row_step_ok;
  assign fire        = valid && ready;

  // Address is computed in AW bits. The true value is always below
  // IMG_W*IMG_H*CH <= 2^AW and every partial term is no larger than the
  // final result, so modular AW-bit arithmetic is exact.
  logic [AW-1:0] row_abs;
  logic [AW-1:0] col_abs;

  assign row_abs = AW'(org_row) + AW'(k_row);
  assign col_abs = AW'(org_col) + AW'(k_col);
  assign addr    = (row_abs * AW'(IMG_W) + col_abs) * AW'(CH) + AW'(k_ch);

  assign win_first = valid && (k_row == '0) && (k_col == '0) && (k_ch == '0);
  assign win_last  = valid && krow_wrap && kcol_wrap && ch_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      stride_q <= 2'd1;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      org_row  <= '0;
      org_col  <= '0;
      k_row    <= '0;
      k_col    <= '0;
      k_ch     <= '0;
    end else if (abort) begin
      // Abort wins over start and over a pending handshake; progress is dropped.
      state   <= S_IDLE;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      org_row <= '0;
      org_col <= '0;
      k_row   <= '0;
      k_col   <= '0;
      k_ch    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_RUN;
            valid    <= 1'b1;
            busy     <= 1'b1;
            stride_q <= (stride == 2'd0) ? 2'd1 : stride;
            org_row  <= '0;
            org_col  <= '0;
            k_row    <= '0;
            k_col    <= '0;
            k_ch     <= '0;
          end
        end

        S_RUN: begin
          if (fire) begin
            if (last_beat) begin
              state   <= S_DONE;
              valid   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              org_row <= '0;
              org_col <= '0;
              k_row   <= '0;
              k_col   <= '0;
              k_ch    <= '0;
            end else if (!ch_wrap) begin
              k_ch <= k_ch + HW'(1);
            end else begin
              k_ch <= '0;
              if (!kcol_wrap) begin
                k_col <= k_col + KW'(1);
              end else begin
                k_col <= '0;
                if (!krow_wrap) begin
                  k_row <= k_row + KW'(1);
                end else begin
                  k_row <= '0;
                  // Window finished: step the origin, columns first.
                  if (col_step_ok) begin
                    org_col <= col_next[CWD-1:0];
                  end else begin
                    org_col <= '0;
                    org_row <= row_next[RW-1:0];
                  end
                end
              end
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_scanner.sv
module tb_conv_window_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] stride;
  logic       abort;
  logic       ready;

  // Instance A: 5x5, K=3, CH=1
  logic       a_valid, a_win_first, a_win_last, a_busy, a_done;
  logic [2:0] a_org_row, a_org_col;
  logic [1:0] a_k_row, a_k_col;
  logic [0:0] a_k_ch;
  logic [4:0] a_addr;

  // Instance B: defaults 8x8, K=3, CH=3
  logic       b_valid, b_win_first, b_win_last, b_busy, b_done;
  logic [2:0] b_org_row, b_org_col;
  logic [1:0] b_k_row, b_k_col;
  logic [1:0] b_k_ch;
  logic [7:0] b_addr;

  always #5 clk = ~clk;

  conv_window_scanner #(.IMG_W(5), .IMG_H(5), .K(3), .CH(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stride(stride), .abort(abort), .ready(ready),
    .valid(a_valid), .org_row(a_org_row), .org_col(a_org_col), .k_row(a_k_row),
    .k_col(a_k_col), .k_ch(a_k_ch), .addr(a_addr), .win_first(a_win_first),
    .win_last(a_win_last), .busy(a_busy), .done(a_done)
  );

  conv_window_scanner dut_b (
    .clk(clk), .rst(rst), .start(start), .stride(stride), .abort(abort), .ready(ready),
    .valid(b_valid), .org_row(b_org_row), .org_col(b_org_col), .k_row(b_k_row),
    .k_col(b_k_col), .k_ch(b_k_ch), .addr(b_addr), .win_first(b_win_first),
    .win_last(b_win_last), .busy(b_busy), .done(b_done)
  );

  // Selected instance, widened for the checker
  bit sel;
  int o_orow, o_ocol, o_kr, o_kc, o_kch, o_addr;
  bit o_valid, o_first, o_last, o_busy, o_done;

  always_comb begin
    o_orow = 0; o_ocol = 0; o_kr = 0; o_kc = 0; o_kch = 0; o_addr = 0;
    o_valid = 0; o_first = 0; o_last = 0; o_busy = 0; o_done = 0;
    if (sel) begin
      o_orow = int'(b_org_row); o_ocol = int'(b_org_col); o_kr = int'(b_k_row);
      o_kc = int'(b_k_col); o_kch = int'(b_k_ch); o_addr = int'(b_addr);
      o_valid = b_valid; o_first = b_win_first; o_last = b_win_last;
      o_busy = b_busy; o_done = b_done;
    end else begin
      o_orow = int'(a_org_row); o_ocol = int'(a_org_col); o_kr = int'(a_k_row);
      o_kc = int'(a_k_col); o_kch = int'(a_k_ch); o_addr = int'(a_addr);
      o_valid = a_valid; o_first = a_win_first; o_last = a_win_last;
      o_busy = a_busy; o_done = a_done;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(int orow, int ocol, int kr, int kc, int kch, int ad,
                                     bit first, bit last, bit vld, bit bsy, bit dn);
    return {16'd0, 8'(orow), 8'(ocol), 4'(kr), 4'(kc), 4'(kch), 16'(ad),
            first, last, vld, bsy, dn, 3'd0};
  endfunction

  function automatic logic [63:0] obs();
    return pk(o_orow, o_ocol, o_kr, o_kc, o_kch, o_addr, o_first, o_last, o_valid, o_busy, o_done);
  endfunction

  // Reference model: the full beat list from plain nested loops over windows.
  typedef struct {
    int orow, ocol, kr, kc, kch, ad;
    bit first, last;
  } beat_t;
  beat_t exp_q[$];

  function automatic void build(int h, int w, int k, int ch, int s);
    beat_t b;
    exp_q.delete();
    for (int r = 0; r <= h - k; r += s)
      for (int c = 0; c <= w - k; c += s)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++)
            for (int kch = 0; kch < ch; kch++) begin
              b.orow = r; b.ocol = c; b.kr = kr; b.kc = kc; b.kch = kch;
              b.ad = ((r + kr) * w + c + kc) * ch + kch;
              b.first = (kr == 0 && kc == 0 && kch == 0);
              b.last = (kr == k - 1 && kc == k - 1 && kch == ch - 1);
              exp_q.push_back(b);
            end
  endfunction

  int last_addr;

  // cut_kind: 0 none, 1 reset at cut_beat, 2 abort(+start) at cut_beat
  task automatic run_scan(input int st, input int pct, input int cut_kind, input int cut_beat,
                          input bit start_in_run);
    int h, w, k, ch, s, beat, nf, nl, wr, wc;
    bit finished;
    h = sel ? 8 : 5; w = h; k = 3; ch = sel ? 3 : 1;
    s = (st == 0) ? 1 : st;
    build(h, w, k, ch, s);
    wr = (h - k) / s + 1;
    wc = (w - k) / s + 1;
    beat = 0; nf = 0; nl = 0; finished = 0;
    // Park both instances in IDLE before launching.
    @(negedge clk); abort = 1'b1; start = 1'b0;
    @(negedge clk); abort = 1'b0; start = 1'b1; stride = 2'(st); ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      if (cut_kind == 1 && beat == cut_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_scan", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); rst = 1'b0;
        return;
      end
      if (cut_kind == 2 && beat == cut_beat) begin
        abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        chk("abort_idle", {o_valid, o_busy, o_done}, 3'b000);
        @(negedge clk);
        chk("abort_no_done", {o_valid, o_busy, o_done}, 3'b000);
        return;
      end
      if (beat == exp_q.size()) begin
        chk("done_pulse", {o_valid, o_busy, o_done}, 3'b001);
        @(negedge clk);
        chk("done_clear", {o_valid, o_busy, o_done}, 3'b000);
        finished = 1;
      end else begin
        chk($sformatf("beat%0d", beat), obs(),
            pk(exp_q[beat].orow, exp_q[beat].ocol, exp_q[beat].kr, exp_q[beat].kc,
               exp_q[beat].kch, exp_q[beat].ad, exp_q[beat].first, exp_q[beat].last, 1, 1, 0));
        stride = 2'($urandom_range(3));
        start = start_in_run && beat >= 5 && beat < 8;
        ready = ($urandom_range(99) < pct);
        if (ready && o_valid) begin
          if (o_first) nf++;
          if (o_last) nl++;
          last_addr = o_addr;
          beat++;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("scan_finished", 64'(finished), 64'd1);
    chk("beat_count", 64'(beat), 64'(wr * wc * k * k * ch));
    chk("win_first_count", 64'(nf), 64'(wr * wc));
    chk("win_last_count", 64'(nl), 64'(wr * wc));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stride = 2'd0; abort = 1'b0; ready = 1'b0; sel = 0;
    last_addr = -1;
    repeat (2) @(negedge clk);
    chk("reset_a", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sel = 1; #1;
    chk("reset_b", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // 5x5, K=3, CH=1 at strides 1, 2, 3 and 0
    sel = 0;
    run_scan(1, 100, 0, 0, 0);
    run_scan(2, 100, 0, 0, 0);
    chk("s2_final_addr", 64'(last_addr), 64'd24);
    run_scan(3, 100, 0, 0, 0);
    run_scan(0, 100, 0, 0, 0);
    run_scan(2, 55, 0, 0, 1);

    // Defaults, random backpressure, start pulsed while running
    sel = 1;
    run_scan(1, 60, 0, 0, 1);
    chk("b_s1_final_addr", 64'(last_addr), 64'd191);
    run_scan(1, 70, 1, 40, 0);
    run_scan(1, 65, 0, 0, 0);
    run_scan(2, 50, 2, 20, 0);
    run_scan(3, 50, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_scanner.md
# conv_window_scanner

Parametrised sliding-window sequencer for the 3D convolution datapath. It replaces fixed-limit position and window counters with one nested iterator. The iterator walks every kernel window over an IMG_H x IMG_W x CH input feature map at a runtime stride. For each window element it emits the window origin, the kernel offsets, the channel and the linear input address, one beat per cycle, under a valid/ready handshake to the MAC stage.

## Interface
- IMG_W, 8, input feature-map width (columns)
- IMG_H, 8, input feature-map height (rows)
- K, 3, kernel side; legal only if K <= IMG_W and K <= IMG_H
- CH, 3, input channel count, >= 1
- Derived: RW = $clog2(IMG_H), CWD = $clog2(IMG_W), KW = $clog2(K), HW = $clog2(CH), AW = $clog2(IMG_W*IMG_H*CH); each is at least 1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch a scan; sampled only in IDLE
- stride  in  2  window step, rows and columns; latched at start; value 0 treated as 1
- abort  in  1  synchronous; forces IDLE next cycle, no done
- ready  in  1  downstream accepts the current beat
- valid  out  1  beat present
- org_row  out  RW  window origin row
- org_col  out  CWD  window origin column
- k_row  out  KW  kernel row offset
- k_col  out  KW  kernel column offset
- k_ch  out  HW  channel index
- addr  out  AW  ((org_row+k_row)*IMG_W + org_col+k_col)*CH + k_ch
- win_first  out  1  beat has k_row = k_col = k_ch = 0
- win_last  out  1  beat has k_row = k_col = K-1 and k_ch = CH-1
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start; clears all indices and latches the effective stride s.
  - RUN -> DONE on the handshake of the final beat.
  - DONE -> IDLE unconditionally after one cycle.
  - Any state -> IDLE on abort. abort has priority over start and over the handshake.
- start is ignored in RUN and DONE.
- Iteration order, innermost first: k_ch (0..CH-1), k_col (0..K-1), k_row (0..K-1), org_col, org_row.
  - org_col steps 0, s, 2s, ... while org_col + s <= IMG_W-K. It then wraps to 0 and org_row advances.
  - org_row steps the same way against IMG_H-K.
- Windows per axis: floor((IMG-K)/s)+1. Total beats: rows*cols*K*K*CH.
- Indices advance only on valid && ready. When ready is low, every output holds stable.
- Stride comparisons use RW+2 / CWD+2 bit arithmetic so that origin + s never wraps.
- addr is computed combinationally from the registered indices. It must be exact for every legal parameter set; no truncation below AW bits.
- Reset, or abort, mid-scan: all progress is discarded. The next start begins again at origin (0,0).

## Timing
- Reset values:
  - valid = 0, busy = 0, done = 0.
  - org_row, org_col, k_row, k_col, k_ch = 0, addr = 0.
  - win_first = 0, win_last = 0 (both are gated by valid).
  - State = IDLE; latched stride = 1.
- Latency: start is sampled high at edge N; valid and busy are high from N+1, with the first beat at origin (0,0).
- Throughput: one beat per cycle while ready = 1.
- valid stays high continuously from the first beat through the final beat, independent of ready.
- Final handshake at edge M:
  - valid and busy go low and done goes high during M+1.
  - State is IDLE from M+2.
  - A start at M+2 launches a new scan.
- The stride input may change during RUN without effect.

## Test plan
- IMG 5x5, K=3, CH=1, stride=1 -> exactly 81 beats and 9 windows; origins row-major (0,0)..(2,2); done pulses once, one cycle after beat 81.
- Same geometry, stride=2 -> 36 beats with origins (0,0), (0,2), (2,0), (2,2). The final beat has addr = 24, and win_last = 1 only on beats 9, 18, 27 and 36.
- Same geometry, stride=3 -> 1 window, 9 beats. stride=0 -> identical to the stride=1 run.
- Defaults (8x8, K=3, CH=3), stride=1, ready toggled pseudo-randomly -> 36*27 = 972 beats; outputs stay stable whenever valid && !ready; the addr sequence matches the reference model.
- rst asserted at beat 40 -> all outputs go to reset values immediately. A subsequent start restarts at addr 0 with win_first = 1.
- abort at beat 20 with start also high -> IDLE next cycle and no done. A start in RUN is ignored; a start in IDLE after abort begins at origin (0,0).
